cmp_zelg_serial: RTL and testbench



---
 rtl/cmp_zelg_pkg.sv | 22 ++
 rtl/cmp_zelg_digit.sv | 14 +
 rtl/cmp_zelg_serial.sv | 116 +++++++++++
 tb/tb_cmp_zelg_serial.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cmp_zelg_pkg.sv
// Shared definitions for the serial ZELG comparator: state encoding,
// digit-count helper and flag bit positions.
package cmp_zelg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_E = 1;
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_G = 3;
  localparam int unsigned FLAG_W = 4;

  // Number of digits needed to cover a width (ceil division).
  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return (width + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/cmp_zelg_digit.sv
// Combinational unsigned compare of one digit.
module cmp_zelg_digit #(
  parameter int unsigned p_DIGIT = 1
) (
  input  logic [p_DIGIT-1:0] a,
  input  logic [p_DIGIT-1:0] b,
  output logic               eq_c,
  output logic               lt_c
);

  assign eq_c = (a == b);
  assign lt_c = (a < b);

endmodule

// File: rtl/cmp_zelg_serial.sv
// Multi-cycle ZELG comparator: scans operands MSB-first one digit per cycle
// and stops at the first differing digit.
module cmp_zelg_serial
  import cmp_zelg_pkg::*;
#(
  parameter int unsigned p_WIDTH     = 16,
  parameter int unsigned p_DIGIT     = 1,
  parameter int unsigned p_SIGNED_EN = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [p_WIDTH-1:0] i_a,
  input  logic [p_WIDTH-1:0] i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_z,
  output logic               o_e,
  output logic               o_l,
  output logic               o_g
);

  localparam int unsigned N   = num_digits(p_WIDTH, p_DIGIT);
  localparam int unsigned EXT = N * p_DIGIT;
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;

  state_t              state;
  logic [EXT-1:0]      a_sh;
  logic [EXT-1:0]      b_sh;
  logic [IW-1:0]       idx;
  logic                z_lat;
  logic [FLAG_W-1:0]   flags;
  logic                busy;
  logic                done;

  logic                sgn_c;
  logic [p_WIDTH-1:0]  a_mod_c;
  logic [p_WIDTH-1:0]  b_mod_c;
  logic                dig_eq_c;
  logic                dig_lt_c;
  logic                last_c;

  // Offset-binary: flipping the sign bit makes an unsigned compare signed.
  always_comb begin
    sgn_c   = (p_SIGNED_EN != 0) && i_signed;
    a_mod_c = i_a;
    b_mod_c = i_b;
    a_mod_c[p_WIDTH-1] = i_a[p_WIDTH-1] ^ sgn_c;
    b_mod_c[p_WIDTH-1] = i_b[p_WIDTH-1] ^ sgn_c;
  end

  cmp_zelg_digit #(.p_DIGIT(p_DIGIT)) u_digit (
    .a    (a_sh[EXT-1 -: p_DIGIT]),
    .b    (b_sh[EXT-1 -: p_DIGIT]),
    .eq_c (dig_eq_c),
    .lt_c (dig_lt_c)
  );

  assign last_c = !dig_eq_c || (idx == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
      z_lat <= 1'b0;
      flags <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sh  <= EXT'(a_mod_c);
            b_sh  <= EXT'(b_mod_c);
            z_lat <= (i_a == '0);
            idx   <= IW'(N - 1);
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (last_c) begin
            // Flags land together with the done pulse.
            flags[FLAG_Z] <= z_lat;
            flags[FLAG_E] <= dig_eq_c;
            flags[FLAG_L] <= !dig_eq_c && dig_lt_c;
            flags[FLAG_G] <= !dig_eq_c && !dig_lt_c;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            a_sh <= a_sh << p_DIGIT;
            b_sh <= b_sh << p_DIGIT;
            idx  <= idx - IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = busy;
  assign o_done = done;
  assign o_z    = flags[FLAG_Z];
  assign o_e    = flags[FLAG_E];
  assign o_l    = flags[FLAG_L];
  assign o_g    = flags[FLAG_G];

endmodule

// File: tb/tb_cmp_zelg_serial.sv
// Directed bench for cmp_zelg_serial (8-bit/2-bit digits, plus a 5-bit/2-bit instance).
module tb_cmp_zelg_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, sgn;
  logic [7:0] a, b;
  logic       busy, done, z, e, l, g;
  logic [3:0] fl;

  logic       start5, sgn5;
  logic [4:0] a5, b5;
  logic       busy5, done5, z5, e5, l5, g5;

  int n_tests = 0;
  int n_fail  = 0;

  assign fl = {g, l, e, z};

  cmp_zelg_serial #(.p_WIDTH(8), .p_DIGIT(2), .p_SIGNED_EN(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_signed(sgn),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
    .o_z(z), .o_e(e), .o_l(l), .o_g(g)
  );

  cmp_zelg_serial #(.p_WIDTH(5), .p_DIGIT(2), .p_SIGNED_EN(1)) dut5 (
    .i_clk(clk), .i_reset(reset), .i_start(start5), .i_signed(sgn5),
    .i_a(a5), .i_b(b5), .o_busy(busy5), .o_done(done5),
    .o_z(z5), .o_e(e5), .o_l(l5), .o_g(g5)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One operation; flags ordered {g,l,e,z}. Inputs are scrambled during the scan.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input logic [3:0] exp_fl, input int exp_cyc,
                        input logic [3:0] hold_fl, input string tag);
    int   got = -1;
    logic busy_bad = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; sgn = ts; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
      if (!busy) busy_bad = 1'b1;
      if (c == 1) check({tag, " held"}, 32'(fl), 32'(hold_fl));
      if (done) begin
        got = c;
        check({tag, " flags"}, 32'(fl), 32'(exp_fl));
        break;
      end
    end
    check({tag, " done_cyc"}, 32'(got), 32'(exp_cyc));
    check({tag, " busy_scan"}, 32'(busy_bad), 32'(0));
    @(negedge clk);
    check({tag, " busy_after"}, 32'(busy), 32'(0));
    check({tag, " done_after"}, 32'(done), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic saw_done;
    reset = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start5 = 1'b0; sgn5 = 1'b0; a5 = '0; b5 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst flags", 32'(fl), 32'(0));

    run_op(8'h5A, 8'h5A, 1'b0, 4'b0010, 5, 4'b0000, "eq");
    run_op(8'h80, 8'h7F, 1'b0, 4'b1000, 2, 4'b0010, "ugt");
    run_op(8'h80, 8'h7F, 1'b1, 4'b0100, 2, 4'b1000, "slt");
    run_op(8'h00, 8'h01, 1'b0, 4'b0101, 5, 4'b0100, "zlt");
    run_op(8'hFF, 8'hFE, 1'b1, 4'b1000, 5, 4'b0101, "sgt");

    // Start while busy is ignored; restart right after DONE is accepted
    @(negedge clk); a = 8'h5A; b = 8'h5A; sgn = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 8'h00;
    @(negedge clk); start = 1'b0;
    check("ign done c3", 32'(done), 32'(0));
    @(negedge clk);
    check("ign done c4", 32'(done), 32'(0));
    @(negedge clk);
    check("ign done c5", 32'(done), 32'(1));
    check("ign flags", 32'(fl), 32'(4'b0010));
    @(negedge clk);
    check("ign idle c6", 32'(busy), 32'(0));
    a = 8'hC0; b = 8'h00; sgn = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("restart done", 32'(done), 32'(1));
    check("restart flags", 32'(fl), 32'(4'b1000));
    @(negedge clk);

    // Reset mid-scan
    saw_done = 1'b0;
    @(negedge clk); a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(negedge clk); start = 1'b0; saw_done |= done;
    @(negedge clk); saw_done |= done;
    @(negedge clk); reset = 1'b1; saw_done |= done;
    @(negedge clk); reset = 1'b0; saw_done |= done;
    check("mrst busy", 32'(busy), 32'(0));
    check("mrst flags", 32'(fl), 32'(0));
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("mrst no_done", 32'(saw_done), 32'(0));

    // 5-bit, 2-bit digits: signed -16 < 15 found on the top digit
    @(negedge clk); a5 = 5'b10000; b5 = 5'b01111; sgn5 = 1'b1; start5 = 1'b1;
    @(negedge clk); start5 = 1'b0;
    check("w5 done c1", 32'(done5), 32'(0));
    @(negedge clk);
    check("w5 done c2", 32'(done5), 32'(1));
    check("w5 flags", 32'({g5, l5, e5, z5}), 32'(4'b0100));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
